// File: rtl/falcon_pkg.sv
// Shared constants and FSM encoding for the Falcon NTT datapath blocks.
// Modulus, default transform geometry and butterfly latencies live here.
package falcon_pkg;

    localparam int Q          = 12289;
    localparam int LOGN_DEF   = 10;
    localparam int LAT_CT_DEF = 4;
    localparam int LAT_GS_DEF = 6;
    localparam int RD_LAT_DEF = 1;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/falcon_ntt_addr_gen.sv
// Combinational butterfly address generator: (stage, index, mode) -> (a, b, twiddle).
// Every product reduces to a power of two, so shifts and masks suffice.
module falcon_ntt_addr_gen
    import falcon_pkg::*;
#(
    parameter int LOGN = LOGN_DEF,
    parameter int SW   = $clog2(LOGN),
    parameter int KW   = LOGN - 1
) (
    input  logic [SW-1:0]   s,
    input  logic [KW-1:0]   k,
    input  logic            mode,
    output logic [LOGN-1:0] a,
    output logic [LOGN-1:0] b,
    output logic [LOGN-1:0] tw_addr
);

    logic [LOGN-1:0] one;
    logic [LOGN-1:0] kk;
    logic [LOGN-1:0] t;
    logic [LOGN-1:0] jj;
    logic [LOGN-1:0] grp;
    int              sh;

    // sh = log2(t): the half-span shrinks with s for CT and grows with s for GS.
    always_comb begin
        one     = LOGN'(1);
        kk      = LOGN'(k);
        sh      = (mode == MODE_INTT) ? int'(s) : (LOGN - 1 - int'(s));
        t       = one << sh;
        jj      = kk & (t - one);
        grp     = kk >> sh;
        a       = (grp << (sh + 1)) | jj;
        b       = a | t;
        tw_addr = (one << (LOGN - 1 - sh)) | grp;
    end

endmodule

// File: rtl/falcon_ntt_ctrl.sv
// Issue-side sequencer for one Falcon butterfly: per-stage address issue,
// pipeline drain between stages and a delay line producing write-back strobes.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; mode latched on the start cycle
//   ST_RUN   | one butterfly issued per cycle, k = 0 .. N/2-1
//   ST_DRAIN | D = RD_LAT + LAT(mode) cycles with no reads, then next stage
//   ST_DONE  | single-cycle done pulse, back to idle
module falcon_ntt_ctrl
    import falcon_pkg::*;
#(
    parameter int LOGN   = LOGN_DEF,
    parameter int LAT_CT = LAT_CT_DEF,
    parameter int LAT_GS = LAT_GS_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            bf_ct,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic            tw_inv,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int KW   = LOGN - 1;
    localparam int SW   = $clog2(LOGN);
    localparam int DMAX = RD_LAT + ((LAT_CT > LAT_GS) ? LAT_CT : LAT_GS);
    localparam int IW   = $clog2(DMAX);

    localparam logic [IW-1:0] DM1_CT = IW'(RD_LAT + LAT_CT - 1);
    localparam logic [IW-1:0] DM1_GS = IW'(RD_LAT + LAT_GS - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

    state_t          state_q, state_n;
    logic [SW-1:0]   s_q, s_n;
    logic [KW-1:0]   k_q, k_n;
    logic [IW-1:0]   dcnt_q, dcnt_n;
    logic            mode_q, mode_n;
    logic [IW-1:0]   dm1;

    logic [LOGN-1:0] gen_a, gen_b, gen_tw;

    logic [DMAX-1:0]            line_v, line_v_n;
    logic [DMAX-1:0][LOGN-1:0]  line_a, line_a_n;
    logic [DMAX-1:0][LOGN-1:0]  line_b, line_b_n;

    assign dm1 = (mode_q == MODE_INTT) ? DM1_GS : DM1_CT;

    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        k_n     = k_q;
        dcnt_n  = dcnt_q;
        mode_n  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_RUN;
                    s_n     = '0;
                    k_n     = '0;
                    mode_n  = mode;
                end
            end
            ST_RUN: begin
                if (&k_q) begin
                    state_n = ST_DRAIN;
                    dcnt_n  = dm1;
                end else begin
                    k_n = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == '0) begin
                    if (s_q == S_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                        s_n     = s_q + 1'b1;
                        k_n     = '0;
                    end
                end else begin
                    dcnt_n = dcnt_q - 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Addresses come from the next-state counters so the outputs can be registered
    // and still line up with the cycle in which the FSM is in RUN.
    falcon_ntt_addr_gen #(
        .LOGN (LOGN),
        .SW   (SW),
        .KW   (KW)
    ) u_addr_gen (
        .s       (s_n),
        .k       (k_n),
        .mode    (mode_n),
        .a       (gen_a),
        .b       (gen_b),
        .tw_addr (gen_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            k_q       <= '0;
            dcnt_q    <= '0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bf_ct     <= 1'b0;
            tw_inv    <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            state_q   <= state_n;
            s_q       <= s_n;
            k_q       <= k_n;
            dcnt_q    <= dcnt_n;
            mode_q    <= mode_n;
            busy      <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
            done      <= (state_n == ST_DONE);
            bf_ct     <= ~mode_n;
            tw_inv    <= mode_n;
            rd_en     <= (state_n == ST_RUN);
            rd_addr_a <= gen_a;
            rd_addr_b <= gen_b;
            tw_addr   <= gen_tw;
        end
    end

    // Entries are inserted at depth D-1 so wr_en appears exactly D cycles after rd_en.
    always_comb begin
        line_v_n      = {1'b0, line_v[DMAX-1:1]};
        line_a_n      = {{LOGN{1'b0}}, line_a[DMAX-1:1]};
        line_b_n      = {{LOGN{1'b0}}, line_b[DMAX-1:1]};
        line_v_n[dm1] = rd_en;
        line_a_n[dm1] = rd_addr_a;
        line_b_n[dm1] = rd_addr_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_v <= '0;
            line_a <= '0;
            line_b <= '0;
        end else begin
            line_v <= line_v_n;
            line_a <= line_a_n;
            line_b <= line_b_n;
        end
    end

    assign wr_en     = line_v[0];
    assign wr_addr_a = line_a[0];
    assign wr_addr_b = line_b[0];

endmodule

// File: tb/tb_falcon_ntt_ctrl.sv
// Self-checking bench: per-cycle comparison of both a LOGN=3 and a LOGN=10
// controller against a schedule computed directly from the NTT index formulas.
module tb_falcon_ntt_ctrl;

    localparam int LAT_CT = 4;
    localparam int LAT_GS = 6;
    localparam int RD_LAT = 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd;
        logic       wr;
        logic       inv;
        logic       ct;
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] tw;
        logic [9:0] wa;
        logic [9:0] wb;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, mode;
    logic       busy, done, bf_ct, rd_en, tw_inv, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;

    logic       rst10, start10, mode10;
    logic       busy10, done10, bf_ct10, rd_en10, tw_inv10, wr_en10;
    logic [9:0] rd_addr_a10, rd_addr_b10, tw_addr10, wr_addr_a10, wr_addr_b10;

    int errors = 0;
    int checks = 0;

    falcon_ntt_ctrl #(.LOGN(3), .LAT_CT(LAT_CT), .LAT_GS(LAT_GS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .bf_ct(bf_ct), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .tw_inv(tw_inv), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b)
    );

    falcon_ntt_ctrl #(.LOGN(10), .LAT_CT(LAT_CT), .LAT_GS(LAT_GS), .RD_LAT(RD_LAT)) dut10 (
        .clk(clk), .rst(rst10), .start(start10), .mode(mode10), .busy(busy10), .done(done10),
        .bf_ct(bf_ct10), .rd_en(rd_en10), .rd_addr_a(rd_addr_a10), .rd_addr_b(rd_addr_b10),
        .tw_addr(tw_addr10), .tw_inv(tw_inv10), .wr_en(wr_en10), .wr_addr_a(wr_addr_a10),
        .wr_addr_b(wr_addr_b10)
    );

    // Butterfly issued in cycle c (cycle 0 = start): stage/index by plain division.
    function automatic void ref_issue(input int logn, input int md, input int c,
                                      output bit v, output int a, output int b, output int tw);
        int n, d, per, st, k, t;
        n = 1 << logn; d = RD_LAT + (md != 0 ? LAT_GS : LAT_CT); per = n / 2 + d;
        v = 0; a = 0; b = 0; tw = 0;
        if (c < 1) return;
        st = (c - 1) / per; k = (c - 1) % per;
        if (st >= logn || k >= n / 2) return;
        v = 1;
        if (md == 0) begin t = n >> (st + 1); tw = (1 << st) + k / t; end
        else         begin t = 1 << st;       tw = (n >> (st + 1)) + k / t; end
        a = (k / t) * 2 * t + k % t;
        b = a + t;
    endfunction

    function automatic int ref_done(input int logn, input int md);
        return logn * ((1 << logn) / 2 + RD_LAT + (md != 0 ? LAT_GS : LAT_CT)) + 1;
    endfunction

    function automatic obs_t exp_at(input int logn, input int md, input int c);
        obs_t e; bit v; int a, b, tw, d;
        e = '0;
        d = RD_LAT + (md != 0 ? LAT_GS : LAT_CT);
        ref_issue(logn, md, c, v, a, b, tw);
        e.rd = v; e.a = 10'(a); e.b = 10'(b); e.tw = 10'(tw);
        ref_issue(logn, md, c - d, v, a, b, tw);
        e.wr = v; e.wa = 10'(a); e.wb = 10'(b);
        e.busy = (c >= 1) && (c < ref_done(logn, md));
        e.done = (c == ref_done(logn, md));
        if (e.busy) begin e.inv = md[0]; e.ct = !md[0]; end
        return e;
    endfunction

    function automatic obs_t observe(input bit big);
        obs_t o;
        o = '0;
        if (big) begin
            o.busy = busy10; o.done = done10; o.rd = rd_en10; o.wr = wr_en10;
            if (rd_en10)  begin o.a = rd_addr_a10; o.b = rd_addr_b10; o.tw = tw_addr10; end
            if (wr_en10)  begin o.wa = wr_addr_a10; o.wb = wr_addr_b10; end
            if (busy10)   begin o.inv = tw_inv10; o.ct = bf_ct10; end
        end else begin
            o.busy = busy; o.done = done; o.rd = rd_en; o.wr = wr_en;
            if (rd_en)    begin o.a = 10'(rd_addr_a); o.b = 10'(rd_addr_b); o.tw = 10'(tw_addr); end
            if (wr_en)    begin o.wa = 10'(wr_addr_a); o.wb = 10'(wr_addr_b); end
            if (busy)     begin o.inv = tw_inv; o.ct = bf_ct; end
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t x);
        return $sformatf("bsy=%0b dn=%0b rd=%0b a=%0d b=%0d tw=%0d inv=%0b ct=%0b wr=%0b wa=%0d wb=%0d",
                         x.busy, x.done, x.rd, x.a, x.b, x.tw, x.inv, x.ct, x.wr, x.wa, x.wb);
    endfunction

    // Advances one cycle, drives this cycle's inputs and returns observed/expected.
    task automatic cycle_step(input bit big, input logic st, input logic md, input int c,
                              input int mdl, output obs_t o, output obs_t e);
        @(posedge clk); #1;
        if (big) begin start10 = st; mode10 = md; end
        else     begin start = st;   mode = md;   end
        o = observe(big);
        e = exp_at(big ? 10 : 3, mdl, c);
    endtask

    task automatic test_reset();
        obs_t o, e;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, bf_ct, rd_en, tw_inv, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== '0) begin
            errors++; $display("FAIL reset_small got %s required all zero", fmt(observe(0)));
        end
        checks++;
        if ({busy10, done10, bf_ct10, rd_en10, tw_inv10, wr_en10, rd_addr_a10, rd_addr_b10, tw_addr10, wr_addr_a10, wr_addr_b10} !== '0) begin
            errors++; $display("FAIL reset_big got %s required all zero", fmt(observe(1)));
        end
        rst = 1'b0; rst10 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle_step(0, 1'b0, 1'($urandom), 0, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL reset_idle got %s exp %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_fwd();
        obs_t o, e; int dc;
        dc = -1;
        cycle_step(0, 1'b1, 1'b0, 0, 0, o, e);
        for (int c = 1; c <= 29; c++) begin
            cycle_step(0, 1'b0, 1'b0, c, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL fwd c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
            if (o.done) dc = c;
            if (c == 1) begin
                checks++;
                if ({o.rd, o.a, o.b, o.tw} !== {1'b1, 10'd0, 10'd4, 10'd1}) begin
                    errors++; $display("FAIL fwd_first got %s required rd=1 a=0 b=4 tw=1", fmt(o));
                end
            end
            if (c == 10) begin
                checks++;
                if ({o.rd, o.a, o.b, o.tw} !== {1'b1, 10'd0, 10'd2, 10'd2}) begin
                    errors++; $display("FAIL fwd_stage1 got %s required rd=1 a=0 b=2 tw=2", fmt(o));
                end
            end
        end
        checks++;
        if (dc != 28) begin errors++; $display("FAIL fwd_done_cycle got %0d required 28", dc); end
    endtask

    task automatic test_inv();
        obs_t o, e; int dc;
        dc = -1;
        cycle_step(0, 1'b1, 1'b1, 0, 1, o, e);
        for (int c = 1; c <= 35; c++) begin
            cycle_step(0, 1'b0, 1'($urandom), c, 1, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL inv c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
            if (o.done) dc = c;
            if (c == 1) begin
                checks++;
                if ({o.a, o.b, o.tw, tw_inv, bf_ct} !== {10'd0, 10'd1, 10'd4, 1'b1, 1'b0}) begin
                    errors++; $display("FAIL inv_first got %s inv=%b ct=%b required a=0 b=1 tw=4 inv=1 ct=0", fmt(o), tw_inv, bf_ct);
                end
            end
            if (c == 23) begin
                checks++;
                if ({o.rd, o.a, o.b, o.tw} !== {1'b1, 10'd0, 10'd4, 10'd1}) begin
                    errors++; $display("FAIL inv_stage2 got %s required rd=1 a=0 b=4 tw=1", fmt(o));
                end
            end
        end
        checks++;
        if (dc != 34) begin errors++; $display("FAIL inv_done_cycle got %0d required 34", dc); end
    endtask

    task automatic test_start_ignored();
        obs_t o, e; int dc; logic st;
        dc = -1;
        cycle_step(0, 1'b1, 1'b0, 0, 0, o, e);
        for (int c = 1; c <= 28; c++) begin
            st = (c == 5) || ($urandom_range(0, 3) == 0);
            cycle_step(0, st, (c == 5) ? 1'b1 : 1'($urandom), c, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL start_ignored c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
            if (o.done) dc = c;
        end
        checks++;
        if (dc != 28) begin errors++; $display("FAIL start_ignored_done got %0d required 28", dc); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e; int md, dn;
        for (int r = 0; r < 3; r++) begin
            md = int'($urandom_range(0, 1));
            dn = ref_done(3, md);
            cycle_step(0, 1'b1, md[0], 0, md, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_start r=%0d got %s exp %s", r, fmt(o), fmt(e)); end
            for (int c = 1; c <= dn; c++) begin
                cycle_step(0, 1'b0, 1'($urandom), c, md, o, e);
                checks++;
                if (o !== e) begin errors++; $display("FAIL b2b r=%0d c=%0d got %s exp %s", r, c, fmt(o), fmt(e)); end
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e; int md, dn, gap;
        for (int r = 0; r < 6; r++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                cycle_step(0, 1'b0, 1'($urandom), 0, 0, o, e);
                checks++;
                if (o !== e) begin errors++; $display("FAIL rand_idle r=%0d got %s exp %s", r, fmt(o), fmt(e)); end
            end
            md = int'($urandom_range(0, 1));
            dn = ref_done(3, md);
            cycle_step(0, 1'b1, md[0], 0, md, o, e);
            for (int c = 1; c <= dn; c++) begin
                cycle_step(0, 1'($urandom), 1'($urandom), c, md, o, e);
                checks++;
                if (o !== e) begin errors++; $display("FAIL rand r=%0d c=%0d got %s exp %s", r, c, fmt(o), fmt(e)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o, e; int dc;
        cycle_step(0, 1'b1, 1'b0, 0, 0, o, e);
        for (int c = 1; c <= 12; c++) begin
            cycle_step(0, 1'b0, 1'b0, c, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_pre c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, bf_ct, rd_en, tw_inv, wr_en, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== '0) begin
            errors++; $display("FAIL rst_mid_zero got %s required all zero", fmt(observe(0)));
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle_step(0, 1'b0, 1'b0, 0, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_post i=%0d got %s exp %s", i, fmt(o), fmt(e)); end
        end
        dc = -1;
        cycle_step(0, 1'b1, 1'b0, 0, 0, o, e);
        for (int c = 1; c <= 29; c++) begin
            cycle_step(0, 1'b0, 1'b0, c, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_rerun c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
            if (o.done) dc = c;
        end
        checks++;
        if (dc != 28) begin errors++; $display("FAIL rst_rerun_done got %0d required 28", dc); end
    endtask

    task automatic test_big();
        obs_t o, e; int dc, nrd, nwr, bad_tw;
        dc = -1; nrd = 0; nwr = 0; bad_tw = 0;
        cycle_step(1, 1'b1, 1'b0, 0, 0, o, e);
        for (int c = 1; c <= 5172; c++) begin
            cycle_step(1, 1'($urandom), 1'($urandom), c, 0, o, e);
            checks++;
            if (o !== e) begin errors++; $display("FAIL big c=%0d got %s exp %s", c, fmt(o), fmt(e)); end
            if (o.rd) begin
                nrd++;
                if (o.tw < 10'd1) bad_tw++;
            end
            if (o.wr) nwr++;
            if (o.done && dc < 0) dc = c;
        end
        checks++;
        if (nrd != 5120) begin errors++; $display("FAIL big_rd_count got %0d required 5120", nrd); end
        checks++;
        if (nwr != 5120) begin errors++; $display("FAIL big_wr_count got %0d required 5120", nwr); end
        checks++;
        if (dc != 5171) begin errors++; $display("FAIL big_done_cycle got %0d required 5171", dc); end
        checks++;
        if (bad_tw != 0) begin errors++; $display("FAIL big_tw_range got %0d out-of-range required 0", bad_tw); end
    endtask

    initial begin
        rst = 1'b1; rst10 = 1'b1;
        start = 1'b0; mode = 1'b0; start10 = 1'b0; mode10 = 1'b0;
        test_reset();
        test_fwd();
        test_inv();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_big();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
